// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the peripheral bus: registers the winning request, runs one
// strobe/ack transaction with a timeout, and returns read data with a one-cycle ack.
module periph_bus_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic [31:0] m0_rd,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic [31:0] m1_rd,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wd,
    input  logic [31:0] s_rd,
    input  logic        s_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        owner;
    logic        last;
    logic        err_q;
    logic [7:0]  cnt;
    logic        lat_we;
    logic [3:0]  lat_be;
    logic [31:0] lat_addr;
    logic [31:0] lat_wd;
    logic        grant_m1;
    logic        busy;
    logic        resp;

    // Contention goes to the master that was not served last, unless M0 has fixed priority.
    always_comb begin
        grant_m1 = 1'b0;
        if (m1_req && !m0_req)
            grant_m1 = 1'b1;
        else if (m0_req && m1_req)
            grant_m1 = FIXED_PRIO ? 1'b0 : !last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            err_q    <= 1'b0;
            cnt      <= 8'd0;
            lat_we   <= 1'b0;
            lat_be   <= 4'd0;
            lat_addr <= 32'd0;
            lat_wd   <= 32'd0;
            m0_rd    <= 32'd0;
            m1_rd    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner    <= grant_m1;
                        lat_we   <= grant_m1 ? m1_we   : m0_we;
                        lat_be   <= grant_m1 ? m1_be   : m0_be;
                        lat_addr <= grant_m1 ? m1_addr : m0_addr;
                        lat_wd   <= grant_m1 ? m1_wd   : m0_wd;
                        cnt      <= 8'd0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 8'd1;
                    // A slave ack in the final timeout cycle still counts as success.
                    if (s_ack) begin
                        if (owner) m1_rd <= s_rd;
                        else       m0_rd <= s_rd;
                        err_q <= 1'b0;
                        last  <= owner;
                        state <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        if (owner) m1_rd <= 32'd0;
                        else       m0_rd <= 32'd0;
                        err_q <= 1'b1;
                        last  <= owner;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_BUSY);
    assign resp = (state == ST_RESP);

    assign s_stb  = busy;
    assign s_we   = busy & lat_we;
    assign s_be   = busy ? lat_be   : 4'd0;
    assign s_addr = busy ? lat_addr : 32'd0;
    assign s_wd   = busy ? lat_wd   : 32'd0;

    assign m0_ack = resp & !owner;
    assign m1_ack = resp & owner;
    assign m0_err = m0_ack & err_q;
    assign m1_err = m1_ack & err_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: a round-robin instance and a fixed-priority instance
// share all inputs; cycle vectors plus directed multi-cycle sequences.
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_be = 4'h3;
    logic [31:0] m0_addr = 32'h7F10, m0_wd = 32'hA5A5A5A5;
    logic        m1_req = 1'b0, m1_we = 1'b1;
    logic [3:0]  m1_be = 4'hF;
    logic [31:0] m1_addr = 32'h7F00, m1_wd = 32'h12345678;
    logic [31:0] s_rd = 32'd0;
    logic        s_ack = 1'b0;

    logic [31:0] m0_rd, m1_rd, s_addr, s_wd;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_stb, s_we;
    logic [3:0]  s_be;
    logic [31:0] fp_m0_rd, fp_m1_rd, fp_s_addr, fp_s_wd;
    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_s_stb, fp_s_we;
    logic [3:0]  fp_s_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_rd(m0_rd), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_rd(m1_rd), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_stb(s_stb), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wd(s_wd),
        .s_rd(s_rd), .s_ack(s_ack)
    );

    periph_bus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(16)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_rd(fp_m0_rd), .m0_ack(fp_m0_ack), .m0_err(fp_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_rd(fp_m1_rd), .m1_ack(fp_m1_ack), .m1_err(fp_m1_err),
        .s_stb(fp_s_stb), .s_we(fp_s_we), .s_be(fp_s_be), .s_addr(fp_s_addr), .s_wd(fp_s_wd),
        .s_rd(s_rd), .s_ack(s_ack)
    );

    typedef struct packed {
        logic        rst;
        logic        req0;
        logic        req1;
        logic        sack;
        logic [31:0] srd;
        logic        stb;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] addr;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  ack_fp;
    } vec_t;

    vec_t vq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0; s_rd = 32'd0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;

        // rst req0 req1 sack srd | stb ack err addr rd0 rd1 ack_fp
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,    32'h0,        32'h0,        2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 2'b00, 32'h7F10, 32'h0,        32'h0,        2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b01, 2'b00, 32'h0,    32'hDEADBEEF, 32'h0,        2'b01});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,    32'hDEADBEEF, 32'h0,        2'b00});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 2'b00, 2'b00, 32'h0,    32'hDEADBEEF, 32'h0,        2'b00});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,    32'h0,        32'h0,        2'b00});
        // Both masters held with an always-acking slave: RR alternates, fixed priority starves M1.
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h99999999, 1'b1, 2'b00, 2'b00, 32'h7F10, 32'h0,        32'h0,        2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 2'b01, 2'b00, 32'h0,    32'h11111111, 32'h0,        2'b01});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b0, 2'b00, 2'b00, 32'h0,    32'h11111111, 32'h0,        2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'hBBBBBBBB, 1'b1, 2'b00, 2'b00, 32'h7F00, 32'h11111111, 32'h0,        2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0, 2'b10, 2'b00, 32'h0,    32'h11111111, 32'h22222222, 2'b01});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,    32'h11111111, 32'h22222222, 2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 2'b00, 2'b00, 32'h7F10, 32'h11111111, 32'h22222222, 2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0, 2'b01, 2'b00, 32'h0,    32'h33333333, 32'h22222222, 2'b01});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,    32'h33333333, 32'h22222222, 2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 2'b00, 2'b00, 32'h7F00, 32'h33333333, 32'h22222222, 2'b00});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b0, 2'b10, 2'b00, 32'h0,    32'h33333333, 32'h44444444, 2'b01});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,    32'h33333333, 32'h44444444, 2'b00});

        step();
        foreach (vq[i]) begin
            rst_n  = !vq[i].rst;
            m0_req = vq[i].req0;
            m1_req = vq[i].req1;
            s_ack  = vq[i].sack;
            s_rd   = vq[i].srd;
            step();
            chk($sformatf("v%0d.stb", i), 32'(s_stb), 32'(vq[i].stb));
            chk($sformatf("v%0d.ack", i), 32'({m1_ack, m0_ack}), 32'(vq[i].ack));
            chk($sformatf("v%0d.err", i), 32'({m1_err, m0_err}), 32'(vq[i].err));
            chk($sformatf("v%0d.addr", i), s_addr, vq[i].addr);
            chk($sformatf("v%0d.rd0", i), m0_rd, vq[i].rd0);
            chk($sformatf("v%0d.rd1", i), m1_rd, vq[i].rd1);
            chk($sformatf("v%0d.ack_fp", i), 32'({fp_m1_ack, fp_m0_ack}), 32'(vq[i].ack_fp));
        end

        // Timeout: first give M1 a nonzero Rd, then a write that is never acked.
        do_reset();
        m1_req = 1'b1; step();
        s_ack = 1'b1; s_rd = 32'hCAFEF00D; step();
        s_ack = 1'b0; m1_req = 1'b0;
        chk("to.pre_rd1", m1_rd, 32'hCAFEF00D);
        step();
        m1_req = 1'b1; step();
        chk("to.s_we", 32'(s_we), 32'd1);
        chk("to.s_be", 32'(s_be), 32'hF);
        chk("to.s_wd", s_wd, 32'h12345678);
        chk("to.s_addr", s_addr, 32'h7F00);
        n = 0;
        while (s_stb && n < 40) begin
            n++;
            step();
        end
        chk("to.stb_cycles", 32'(n), 32'd16);
        chk("to.m1_ack", 32'(m1_ack), 32'd1);
        chk("to.m1_err", 32'(m1_err), 32'd1);
        chk("to.m1_rd", m1_rd, 32'd0);
        chk("to.m0_ack", 32'(m0_ack), 32'd0);
        m1_req = 1'b0; step();
        chk("to.idle_stb", 32'(s_stb), 32'd0);
        chk("to.idle_ack", 32'(m1_ack), 32'd0);

        // Ack arriving in the last BUSY cycle before timeout.
        do_reset();
        m0_req = 1'b1; step();
        for (int k = 0; k < 15; k++) step();
        chk("lastack.stb", 32'(s_stb), 32'd1);
        s_ack = 1'b1; s_rd = 32'h0BADF00D; step();
        chk("lastack.ack", 32'(m0_ack), 32'd1);
        chk("lastack.err", 32'(m0_err), 32'd0);
        chk("lastack.rd0", m0_rd, 32'h0BADF00D);
        s_ack = 1'b0; m0_req = 1'b0; step();

        // Master inputs changing during BUSY do not disturb the bus; M1 waits for RESP.
        do_reset();
        m0_req = 1'b1; step();
        m0_addr = 32'h00001234; m0_wd = 32'h0; m1_req = 1'b1; step();
        chk("hold.s_addr", s_addr, 32'h7F10);
        chk("hold.s_wd", s_wd, 32'hA5A5A5A5);
        chk("hold.s_be", 32'(s_be), 32'h3);
        s_ack = 1'b1; s_rd = 32'h600DCAFE; step();
        chk("hold.m0_ack", 32'(m0_ack), 32'd1);
        chk("hold.m1_ack", 32'(m1_ack), 32'd0);
        chk("hold.resp_stb", 32'(s_stb), 32'd0);
        s_ack = 1'b0; m0_req = 1'b0; m0_addr = 32'h7F10; m0_wd = 32'hA5A5A5A5; step();
        chk("hold.idle_stb", 32'(s_stb), 32'd0);
        step();
        chk("hold.m1_stb", 32'(s_stb), 32'd1);
        chk("hold.m1_addr", s_addr, 32'h7F00);
        chk("hold.m1_we", 32'(s_we), 32'd1);
        s_ack = 1'b1; s_rd = 32'h0; step();
        chk("hold.m1_ack", 32'(m1_ack), 32'd1);
        s_ack = 1'b0; m1_req = 1'b0; step();

        // Asynchronous reset in the middle of a BUSY cycle.
        m0_req = 1'b1; step();
        chk("arst.pre_stb", 32'(s_stb), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.stb", 32'(s_stb), 32'd0);
        chk("arst.addr", s_addr, 32'd0);
        chk("arst.wd", s_wd, 32'd0);
        chk("arst.rd0", m0_rd, 32'd0);
        chk("arst.ack", 32'({m1_ack, m0_ack}), 32'd0);
        m1_req = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("arst.grant_stb", 32'(s_stb), 32'd1);
        chk("arst.grant_addr", s_addr, 32'h7F10);
        s_ack = 1'b1; s_rd = 32'h0; step();
        chk("arst.grant_m0", 32'({m1_ack, m0_ack}), 32'b01);
        s_ack = 1'b0; m0_req = 1'b0; m1_req = 1'b0; step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
